// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter and 4-bit nibble write engine for an HD44780-style character LCD.
// Each granted byte is sent as two E-strobed nibbles, followed by the controller execution wait.
module lcd_bus_arbiter #(
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned E_CYC        = 16,
    parameter int unsigned HOLD_CYC     = 4,
    parameter int unsigned WAIT_CYC     = 2500,
    parameter int unsigned CLR_WAIT_CYC = 82000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic       rs0_i,
    input  logic [7:0] data0_i,
    output logic       ack0_o,
    input  logic       req1_i,
    input  logic       rs1_i,
    input  logic [7:0] data1_i,
    output logic       ack1_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [3:0] lcd_db_o,
    output logic       busy_o
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MaxCyc = max2(max2(CLR_WAIT_CYC, WAIT_CYC),
                                          max2(E_CYC, max2(SETUP_CYC, HOLD_CYC)));
    // Counter is loaded with duration-1, so it only has to reach MaxCyc-1.
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] EnLd    = CntW'(E_CYC - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] WaitLd  = CntW'(WAIT_CYC - 1);
    localparam logic [CntW-1:0] ClrLd   = CntW'(CLR_WAIT_CYC - 1);

    typedef enum logic [3:0] {
        StIdle, StSuH, StEnH, StHdH, StSuL, StEnL, StHdL, StWait, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ptr_q, ptr_d;
    logic            gnt_q, gnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            win, cnt_zero, clr_cmd, hi_d, lo_d;

    always_comb begin
        win      = (req0_i && req1_i) ? ptr_q : req1_i;
        cnt_zero = (cnt_q == '0);
        // Clear display / return home need the long execution time.
        clr_cmd  = !rs_q && (data_q[7:2] == 6'd0);
        state_d  = state_q;
        cnt_d    = cnt_zero ? cnt_q : cnt_q - 1'b1;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        rs_d     = rs_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle: begin
                if (req0_i || req1_i) begin
                    state_d = StSuH;
                    cnt_d   = SetupLd;
                    gnt_d   = win;
                    ptr_d   = !win;
                    rs_d    = win ? rs1_i : rs0_i;
                    data_d  = win ? data1_i : data0_i;
                end
            end
            StSuH: if (cnt_zero) begin state_d = StEnH; cnt_d = EnLd;    end
            StEnH: if (cnt_zero) begin state_d = StHdH; cnt_d = HoldLd;  end
            StHdH: if (cnt_zero) begin state_d = StSuL; cnt_d = SetupLd; end
            StSuL: if (cnt_zero) begin state_d = StEnL; cnt_d = EnLd;    end
            StEnL: if (cnt_zero) begin state_d = StHdL; cnt_d = HoldLd;  end
            StHdL: begin
                if (cnt_zero) begin
                    state_d = StWait;
                    cnt_d   = clr_cmd ? ClrLd : WaitLd;
                end
            end
            StWait: if (cnt_zero) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        hi_d = (state_d == StSuH) || (state_d == StEnH) || (state_d == StHdH);
        lo_d = (state_d == StSuL) || (state_d == StEnL) || (state_d == StHdL);
    end

    // Outputs are decoded from the next state so the pins change on the same edge as the FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'd0;
            busy_o   <= 1'b0;
            lcd_e_o  <= 1'b0;
            lcd_rs_o <= 1'b0;
            lcd_db_o <= 4'd0;
            ack0_o   <= 1'b0;
            ack1_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            busy_o   <= (state_d != StIdle);
            lcd_e_o  <= (state_d == StEnH) || (state_d == StEnL);
            lcd_rs_o <= rs_d && (hi_d || lo_d);
            lcd_db_o <= hi_d ? data_d[7:4] : (lo_d ? data_d[3:0] : 4'd0);
            ack0_o   <= (state_d == StDone) && !gnt_d;
            ack1_o   <= (state_d == StDone) && gnt_d;
        end
    end

    assign lcd_rw_o = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: per-cycle pin trace compared against a timeline model
// derived from byte/RS, requester id and the configured phase lengths.
module tb_lcd_bus_arbiter;

    localparam int SU = 2;
    localparam int EN = 3;
    localparam int HD = 2;
    localparam int WT = 5;
    localparam int CW = 20;
    localparam int T  = SU + EN + HD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'd0, data1 = 8'd0;
    logic       ack0, ack1, lcd_rs, lcd_rw, lcd_e, busy;
    logic [3:0] lcd_db;

    int chk = 0;
    int err = 0;
    int cyc = 0;

    lcd_bus_arbiter #(
        .SETUP_CYC   (SU),
        .E_CYC       (EN),
        .HOLD_CYC    (HD),
        .WAIT_CYC    (WT),
        .CLR_WAIT_CYC(CW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req0_i  (req0),
        .rs0_i   (rs0),
        .data0_i (data0),
        .ack0_o  (ack0),
        .req1_i  (req1),
        .rs1_i   (rs1),
        .data1_i (data1),
        .ack1_o  (ack1),
        .lcd_rs_o(lcd_rs),
        .lcd_rw_o(lcd_rw),
        .lcd_e_o (lcd_e),
        .lcd_db_o(lcd_db),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input bit rs, input logic [7:0] d);
        return (!rs && d <= 8'h03) ? CW : WT;
    endfunction

    // Expected {busy, rs, e, db, ack0, ack1, rw} o cycles after the accepting edge.
    function automatic logic [9:0] model(input int o, input bit id, input bit rs,
                                         input logic [7:0] d);
        int         w;
        int         p;
        logic       b, r, e, a0, a1;
        logic [3:0] db;
        w  = wait_of(rs, d);
        p  = o % T;
        b  = (o <= 2 * T + w);
        r  = (o < 2 * T) && rs;
        e  = (o < 2 * T) && (p >= SU) && (p < SU + EN);
        db = (o < T) ? d[7:4] : ((o < 2 * T) ? d[3:0] : 4'h0);
        a0 = (o == 2 * T + w) && !id;
        a1 = (o == 2 * T + w) && id;
        return {b, r, e, db, a0, a1, 1'b0};
    endfunction

    function automatic logic [9:0] obs();
        return {busy, lcd_rs, lcd_e, lcd_db, ack0, ack1, lcd_rw};
    endfunction

    task automatic drive(input bit id, input bit r, input logic [7:0] d);
        if (id) begin req1 = 1'b1; rs1 = r; data1 = d; end
        else    begin req0 = 1'b1; rs0 = r; data0 = d; end
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 8 && !ok; g++) begin
            @(negedge clk);
            ok = busy;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        chk++;
        if (obs() !== 10'd0) begin
            err++; $display("FAIL reset_held: got %b required %b", obs(), 10'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk++;
            if (obs() !== 10'd0) begin
                err++; $display("FAIL reset_idle c=%0d: got %b required %b", i, obs(), 10'd0);
            end
        end
    endtask

    task automatic test_single_cmd();
        bit ok; logic [9:0] e; int last;
        drive(1'b0, 1'b0, 8'h28);
        wait_accept(ok);
        chk++;
        if (!ok) begin err++; $display("FAIL single_cmd accept: busy=%b required 1", busy); end
        last = 2 * T + wait_of(1'b0, 8'h28) + 1;
        for (int o = 0; ok && o <= last; o++) begin
            if (o > 0) @(negedge clk);
            e = model(o, 1'b0, 1'b0, 8'h28);
            chk++;
            if (obs() !== e) begin
                err++; $display("FAIL single_cmd o=%0d: got %b required %b", o, obs(), e);
            end
            if (o == last - 1) req0 = 1'b0;
        end
        req0 = 1'b0;
    endtask

    task automatic test_clear_wait();
        logic [7:0] tbl_d [6] = '{8'h01, 8'h02, 8'h03, 8'h06, 8'h01, 8'h04};
        bit         tbl_r [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit ok; logic [9:0] e; int last;
        for (int n = 0; n < 6; n++) begin
            drive(1'b0, tbl_r[n], tbl_d[n]);
            wait_accept(ok);
            chk++;
            if (!ok) begin err++; $display("FAIL clear_wait accept n=%0d: busy=%b required 1", n, busy); end
            last = 2 * T + wait_of(tbl_r[n], tbl_d[n]) + 1;
            for (int o = 0; ok && o <= last; o++) begin
                if (o > 0) @(negedge clk);
                e = model(o, 1'b0, tbl_r[n], tbl_d[n]);
                chk++;
                if (obs() !== e) begin
                    err++;
                    $display("FAIL clear_wait n=%0d o=%0d: got %b required %b", n, o, obs(), e);
                end
                if (o == last - 1) req0 = 1'b0;
            end
            req0 = 1'b0;
        end
    endtask

    task automatic test_data_write();
        bit ok; logic [9:0] e; int last;
        drive(1'b1, 1'b1, 8'h41);
        wait_accept(ok);
        chk++;
        if (!ok) begin err++; $display("FAIL data_write accept: busy=%b required 1", busy); end
        last = 2 * T + wait_of(1'b1, 8'h41) + 1;
        for (int o = 0; ok && o <= last; o++) begin
            if (o > 0) @(negedge clk);
            e = model(o, 1'b1, 1'b1, 8'h41);
            chk++;
            if (obs() !== e) begin
                err++; $display("FAIL data_write o=%0d: got %b required %b", o, obs(), e);
            end
            if (o == last - 1) req1 = 1'b0;
        end
        req1 = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok; logic [9:0] e; int last, k_prev; bit id;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h28);
        drive(1'b1, 1'b1, 8'h41);
        @(negedge clk);
        rst = 1'b0;
        k_prev = 0;
        for (int n = 0; n < 4; n++) begin
            id = n[0];
            wait_accept(ok);
            chk++;
            if (!ok) begin err++; $display("FAIL round_robin accept n=%0d: busy=%b required 1", n, busy); end
            if (ok && n > 0) begin
                chk++;
                if (cyc - k_prev != 2 * T + WT + 2) begin
                    err++;
                    $display("FAIL round_robin spacing n=%0d: got %0d required %0d",
                             n, cyc - k_prev, 2 * T + WT + 2);
                end
            end
            k_prev = cyc;
            last = 2 * T + WT + 1;
            for (int o = 0; ok && o <= last; o++) begin
                if (o > 0) @(negedge clk);
                e = id ? model(o, 1'b1, 1'b1, 8'h41) : model(o, 1'b0, 1'b0, 8'h28);
                chk++;
                if (obs() !== e) begin
                    err++;
                    $display("FAIL round_robin n=%0d o=%0d: got %b required %b", n, o, obs(), e);
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset_mid_e();
        bit ok; logic [9:0] e; int last;
        drive(1'b0, 1'b1, 8'hA5);
        wait_accept(ok);
        chk++;
        if (!ok) begin err++; $display("FAIL reset_mid_e accept: busy=%b required 1", busy); end
        repeat (SU) @(negedge clk);
        chk++;
        if (lcd_e !== 1'b1) begin err++; $display("FAIL reset_mid_e pre_e: got %b required 1", lcd_e); end
        #1 rst = 1'b1;
        #1;
        chk++;
        if (obs() !== 10'd0) begin
            err++; $display("FAIL reset_mid_e async: got %b required %b", obs(), 10'd0);
        end
        @(negedge clk);
        chk++;
        if (obs() !== 10'd0) begin
            err++; $display("FAIL reset_mid_e held: got %b required %b", obs(), 10'd0);
        end
        rst = 1'b0;
        wait_accept(ok);
        chk++;
        if (!ok) begin err++; $display("FAIL reset_mid_e restart: busy=%b required 1", busy); end
        last = 2 * T + wait_of(1'b1, 8'hA5) + 1;
        for (int o = 0; ok && o <= last; o++) begin
            if (o > 0) @(negedge clk);
            e = model(o, 1'b0, 1'b1, 8'hA5);
            chk++;
            if (obs() !== e) begin
                err++; $display("FAIL reset_mid_e o=%0d: got %b required %b", o, obs(), e);
            end
            if (o == last - 1) req0 = 1'b0;
        end
        req0 = 1'b0;
    endtask

    task automatic test_drop_req();
        bit ok; logic [9:0] e; int last;
        drive(1'b1, 1'b0, 8'h9C);
        wait_accept(ok);
        chk++;
        if (!ok) begin err++; $display("FAIL drop_req accept: busy=%b required 1", busy); end
        last = 2 * T + wait_of(1'b0, 8'h9C) + 1;
        for (int o = 0; ok && o <= last; o++) begin
            if (o > 0) @(negedge clk);
            e = model(o, 1'b1, 1'b0, 8'h9C);
            chk++;
            if (obs() !== e) begin
                err++; $display("FAIL drop_req o=%0d: got %b required %b", o, obs(), e);
            end
            if (o == 2) begin req1 = 1'b0; rs1 = 1'b1; data1 = 8'hFF; end
        end
        req1 = 1'b0;
    endtask

    task automatic test_random();
        bit ok, id, r; logic [7:0] d; logic [9:0] e; int last;
        for (int n = 0; n < 12; n++) begin
            id = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom());
            drive(id, r, d);
            wait_accept(ok);
            chk++;
            if (!ok) begin err++; $display("FAIL random accept n=%0d: busy=%b required 1", n, busy); end
            last = 2 * T + wait_of(r, d) + 1;
            for (int o = 0; ok && o <= last; o++) begin
                if (o > 0) @(negedge clk);
                e = model(o, id, r, d);
                chk++;
                if (obs() !== e) begin
                    err++;
                    $display("FAIL random n=%0d id=%0d rs=%0d d=%h o=%0d: got %b required %b",
                             n, id, r, d, o, obs(), e);
                end
                if (o == last - 1) begin req0 = 1'b0; req1 = 1'b0; end
            end
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_clear_wait();
        test_data_write();
        test_round_robin();
        test_reset_mid_e();
        test_drop_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
